exp_share_arbiter: RTL and testbench

- Shares one fixed-latency 8-bit exp unit (exp LUT plus output register) between NUM_REQ independent requesters.
- Round-robin arbitration, one issue per cycle.
- Tracks in-flight tags and steers each exp result back to its originating requester through a one-entry response buffer.
- Sits between softmax/attention lanes and the single shared exp instance.

---
 rtl/exp_share_arbiter_if.sv | 31 +++
 rtl/exp_share_arbiter.sv | 111 +++++++++++
 tb/tb_exp_share_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/exp_share_arbiter_if.sv
// Requester-side bundle for the shared exp arbiter.
// Master is the lane side, slave is the arbiter.
interface exp_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ*DATA_W-1:0] rsp_data;
  logic [NUM_REQ-1:0]        rsp_ready;

  modport master (
    output req_valid,
    output req_data,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/exp_share_arbiter.sv
// Round-robin share of one fixed-latency exp unit
// between NUM_REQ lanes, with per-lane result slots.
module exp_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int EXP_LAT = 2
) (
  input  logic                 clock,
  input  logic                 resetn,
  exp_share_arbiter_if.slave   bus,
  output logic [DATA_W-1:0]    exp_in,
  input  logic [DATA_W-1:0]    exp_out,
  output logic                 idle
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] tag;
  } tag_t;

  logic [NUM_REQ-1:0]        busy;
  logic [NUM_REQ-1:0]        elig;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        drain;
  logic [NUM_REQ-1:0]        rsp_valid_q;
  logic [NUM_REQ*DATA_W-1:0] rsp_data_q;
  logic [IW-1:0]             last;
  logic [IW-1:0]             gidx;
  logic                      found;
  logic [DATA_W-1:0]         gdata;

  // stage 0 tracks exp_in; stage EXP_LAT lines up with exp_out
  tag_t pipe [EXP_LAT+1];

  assign elig  = bus.req_valid & ~busy;
  assign drain = rsp_valid_q & bus.rsp_ready;

  always_comb begin : scan
    int j;
    j     = 0;
    found = 1'b0;
    gidx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(last) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && elig[j]) begin
        found = 1'b1;
        gidx  = IW'(j);
      end
    end
  end

  always_comb begin
    gnt   = '0;
    gdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (found && gidx == IW'(i)) begin
        gnt[i] = 1'b1;
        gdata  = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign idle          = ~|busy;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      busy   <= '0;
      last   <= IW'(NUM_REQ - 1);
      exp_in <= '0;
    end else begin
      busy <= (busy & ~drain) | gnt;
      if (found) begin
        last   <= gidx;
        exp_in <= gdata;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s <= EXP_LAT; s++) pipe[s] <= '0;
    end else begin
      pipe[0] <= '{vld: found, tag: gidx};
      for (int s = 1; s <= EXP_LAT; s++) pipe[s] <= pipe[s-1];
    end
  end

  // slot t is empty whenever tag t emerges, so capture never meets drain
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pipe[EXP_LAT].vld && pipe[EXP_LAT].tag == IW'(i)) begin
          rsp_valid_q[i]                  <= 1'b1;
          rsp_data_q[i*DATA_W +: DATA_W]  <= exp_out;
        end else if (drain[i]) begin
          rsp_valid_q[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_exp_share_arbiter.sv
// Randomized bench for exp_share_arbiter against a
// transaction-level model of arbitration and responses.
module tb_exp_share_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int L = 2;

  logic         clock;
  logic         resetn;
  logic [W-1:0] exp_in;
  logic [W-1:0] exp_out;
  logic         idle;

  exp_share_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

  exp_share_arbiter #(.NUM_REQ(N), .DATA_W(W), .EXP_LAT(L)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .bus     (bus.slave),
    .exp_in  (exp_in),
    .exp_out (exp_out),
    .idle    (idle)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // shared exp unit stand-in: f(x) = x + 1, L register stages
  logic [W-1:0] ep [L];
  always_ff @(posedge clock) begin
    ep[0] <= exp_in + 8'd1;
    for (int k = 1; k < L; k++) ep[k] <= ep[k-1];
  end
  assign exp_out = ep[L-1];

  typedef struct {
    int           tag;
    logic [W-1:0] val;
    int           due;
  } fl_t;

  int           nvec;
  int           nerr;
  int           cyc;
  int           mg;
  int           mlast;
  bit           mbusy [N];
  bit           mrv   [N];
  logic [W-1:0] mrd   [N];
  logic [W-1:0] mexp;
  fl_t          fq [$];

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mbusy[i] = 1'b0;
      mrv[i]   = 1'b0;
      mrd[i]   = '0;
    end
    mlast = N - 1;
    mexp  = '0;
    fq.delete();
  endtask

  task automatic compare();
    logic [N-1:0]   er;
    logic [N-1:0]   ev;
    logic [N*W-1:0] ed;
    bit             eb;
    er = '0;
    ev = '0;
    ed = '0;
    eb = 1'b0;
    if (mg >= 0) er[mg] = 1'b1;
    for (int i = 0; i < N; i++) begin
      ev[i]        = mrv[i];
      ed[i*W +: W] = mrd[i];
      eb           = eb | mbusy[i];
    end
    check("req_ready", 64'(bus.req_ready), 64'(er));
    check("exp_in",    64'(exp_in),        64'(mexp));
    check("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
    check("rsp_data",  64'(bus.rsp_data),  64'(ed));
    check("idle",      64'(idle),          64'(!eb));
  endtask

  // one clock: check at negedge+1, then advance model on posedge
  task automatic cycle();
    logic [N-1:0]   rv;
    logic [N-1:0]   rr;
    logic [N*W-1:0] rd;
    fl_t            keep [$];
    #1;
    rv = bus.req_valid;
    rr = bus.rsp_ready;
    rd = bus.req_data;
    mg = -1;
    if (resetn) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (mlast + k) % N;
        if (mg < 0 && rv[i] && !mbusy[i]) mg = i;
      end
    end
    compare();
    @(posedge clock);
    if (resetn) begin
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (mrv[i] && rr[i]) begin
          mrv[i]   = 1'b0;
          mbusy[i] = 1'b0;
        end
      end
      keep.delete();
      foreach (fq[q]) begin
        if (fq[q].due == cyc) begin
          mrv[fq[q].tag] = 1'b1;
          mrd[fq[q].tag] = fq[q].val;
        end else begin
          keep.push_back(fq[q]);
        end
      end
      fq = keep;
      if (mg >= 0) begin
        mbusy[mg] = 1'b1;
        mlast     = mg;
        mexp      = rd[mg*W +: W];
        fq.push_back('{tag: mg, val: rd[mg*W +: W] + 8'd1,
                       due: cyc + L + 1});
      end
    end
    @(negedge clock);
  endtask

  task automatic drive(logic [N-1:0] v, logic [N-1:0] r);
    bus.req_valid = v;
    bus.rsp_ready = r;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = W'($urandom);
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    cyc  = 0;
    mg   = -1;
    resetn        = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = '1;
    model_reset();
    repeat (3) @(negedge clock);
    #1;
    compare();
    resetn = 1'b1;

    // single op on lane 0
    bus.req_data[0 +: W] = 8'h10;
    drive(4'b0001, 4'b1111);
    cycle();
    drive(4'b0000, 4'b1111);
    repeat (3) cycle();
    #1;
    check("single_rsp_v", 64'(bus.rsp_valid[0]), 64'd1);
    check("single_rsp_d", 64'(bus.rsp_data[0 +: W]), 64'h11);
    repeat (4) cycle();
    check("single_idle", 64'(idle), 64'd1);

    // contention, all four lanes
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = W'(8'hA0 + i);
    drive(4'b1111, 4'b1111);
    repeat (14) cycle();
    drive(4'b0000, 4'b1111);
    repeat (6) cycle();

    // fairness: last grant 2, then 0 and 3 compete
    drive(4'b0100, 4'b1111);
    cycle();
    drive(4'b0000, 4'b1111);
    repeat (6) cycle();
    drive(4'b1001, 4'b1111);
    #1;
    check("rr_first", 64'(bus.req_ready), 64'b1000);
    cycle();
    #1;
    check("rr_second", 64'(bus.req_ready), 64'b0001);
    cycle();
    drive(4'b0000, 4'b1111);
    repeat (6) cycle();

    // backpressure on lane 1
    drive(4'b0111, 4'b1101);
    for (int c = 0; c < 20; c++) begin
      rand_data();
      cycle();
    end
    drive(4'b0111, 4'b1111);
    repeat (10) cycle();
    drive(4'b0000, 4'b1111);
    repeat (6) cycle();

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      rand_data();
      bus.req_valid = N'($urandom);
      bus.rsp_ready = N'($urandom) | N'($urandom);
      cycle();
    end
    drive(4'b0000, 4'b1111);
    repeat (8) cycle();

    // reset one cycle after granting lanes 0 and 1
    drive(4'b0011, 4'b1111);
    rand_data();
    repeat (2) cycle();
    drive(4'b0000, 4'b1111);
    cycle();
    resetn = 1'b0;
    #1;
    model_reset();
    compare();
    cycle();
    resetn = 1'b1;
    repeat (8) cycle();
    check("post_rst_idle", 64'(idle), 64'd1);
    check("post_rst_rspv", 64'(bus.rsp_valid), 64'd0);

    // idle hold: exp_in keeps last operand
    bus.req_data[2*W +: W] = 8'h5C;
    drive(4'b0100, 4'b1111);
    cycle();
    drive(4'b0000, 4'b1111);
    repeat (10) cycle();
    #1;
    check("idle_final", 64'(idle), 64'd1);
    check("idle_exp_in", 64'(exp_in), 64'h5C);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
